// File: rtl/lut_mw_if.sv
// Bus bundle for the multi-plane writable memory LUT (lut_mw).
// Define LUT_MW_SRL_EN to add the mode / shift_out signals of the shift-register option.
interface lut_mw_if #(
    parameter int INPUTS       = 4,
    parameter int WIDTH        = 2,
    parameter int CONFIG_WIDTH = 8
);
    logic [INPUTS-1:0]       addr;
    logic [WIDTH-1:0]        out;
    logic                    cen;
    logic [CONFIG_WIDTH-1:0] config_in;
    logic                    config_done;
    logic [INPUTS-1:0]       waddr;
    logic [WIDTH-1:0]        data_in;
    logic                    write_en;
`ifdef LUT_MW_SRL_EN
    logic                    mode;
    logic [WIDTH-1:0]        shift_out;

    modport master (
        output addr, cen, config_in, waddr, data_in, write_en, mode,
        input  out, config_done, shift_out
    );
    modport slave (
        input  addr, cen, config_in, waddr, data_in, write_en, mode,
        output out, config_done, shift_out
    );
`else
    modport master (
        output addr, cen, config_in, waddr, data_in, write_en,
        input  out, config_done
    );
    modport slave (
        input  addr, cen, config_in, waddr, data_in, write_en,
        output out, config_done
    );
`endif
endinterface

// File: rtl/lut_mw.sv
// Multi-plane writable memory LUT with chunked serial configuration and user writes.
// Define LUT_MW_SRL_EN to add the shift-register (SRL) mode and the shift_out cascade.
module lut_mw #(
    parameter int INPUTS       = 4,
    parameter int WIDTH        = 2,
    parameter int CONFIG_WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    lut_mw_if.slave  bus
);
    localparam int DEPTH    = 2 ** INPUTS;
    localparam int MEM_SIZE = WIDTH * DEPTH;
    localparam int NCHUNK   = MEM_SIZE / CONFIG_WIDTH;
    localparam int CNT_W    = $clog2(NCHUNK + 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD       = 2'd1,
        ST_CONFIGURED = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic                done_r, done_nxt_s;
    logic [MEM_SIZE-1:0] mem_r, mem_nxt_s;
    logic [MEM_SIZE-1:0] wr_flat_s;
    logic                wr_s;
    logic [WIDTH-1:0]    out_s;
`ifdef LUT_MW_SRL_EN
    logic [WIDTH-1:0]    shift_out_s;
`endif

    // State, chunk counter, completion flag and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            done_r  <= 1'b0;
            mem_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            done_r  <= done_nxt_s;
            mem_r   <= mem_nxt_s;
        end
    end

    // Next-state logic: cen always wins, user writes only once configured.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        done_nxt_s  = done_r;
        wr_s        = 1'b0;
        if (bus.cen) begin
            // Entering LOAD clears the counter, and the same edge counts the chunk.
            case (state_r)
                ST_LOAD:       cnt_nxt_s = cnt_r + CNT_W'(1);
                ST_IDLE:       cnt_nxt_s = CNT_W'(1);
                ST_CONFIGURED: cnt_nxt_s = CNT_W'(1);
                default:       cnt_nxt_s = CNT_W'(1);
            endcase
            if (cnt_nxt_s == CNT_W'(NCHUNK)) begin
                state_nxt_s = ST_CONFIGURED;
                done_nxt_s  = 1'b1;
            end else begin
                state_nxt_s = ST_LOAD;
                done_nxt_s  = 1'b0;
            end
        end else if (bus.write_en && (state_r == ST_CONFIGURED)) begin
            wr_s = 1'b1;
        end else begin
            wr_s = 1'b0;
        end
    end

    // Storage update: config chunks enter at the LSBs so the first chunk lands in the MSBs.
    always_comb begin
        mem_nxt_s = mem_r;
        if (bus.cen) begin
            mem_nxt_s = MEM_SIZE'({mem_r, bus.config_in});
        end else if (wr_s) begin
            mem_nxt_s = wr_flat_s;
        end else begin
            mem_nxt_s = mem_r;
        end
    end

    for (genvar p = 0; p < WIDTH; p++) begin : g_plane
        logic [DEPTH-1:0] plane_s;
        logic [DEPTH-1:0] upd_s;

        assign plane_s                       = mem_r[p*DEPTH +: DEPTH];
        assign wr_flat_s[p*DEPTH +: DEPTH]   = upd_s;
        assign out_s[p]                      = plane_s[bus.addr];
`ifdef LUT_MW_SRL_EN
        assign shift_out_s[p]                = plane_s[DEPTH-1];
`endif

        // Candidate plane contents for a user write: random-access bit or one-step shift.
        always_comb begin
            upd_s = plane_s;
`ifdef LUT_MW_SRL_EN
            if (bus.mode) begin
                upd_s = {plane_s[DEPTH-2:0], bus.data_in[p]};
            end else begin
                upd_s[bus.waddr] = bus.data_in[p];
            end
`else
            upd_s[bus.waddr] = bus.data_in[p];
`endif
        end
    end

    assign bus.out         = out_s;
    assign bus.config_done = done_r;
`ifdef LUT_MW_SRL_EN
    assign bus.shift_out   = shift_out_s;
`endif

endmodule

// File: tb/tb_lut_mw.sv
// Directed self-checking bench for lut_mw (INPUTS=4, WIDTH=2, CONFIG_WIDTH=8, four chunks).
// SRL scenarios are included when LUT_MW_SRL_EN is defined.
module tb_lut_mw;
    localparam int INPUTS = 4;
    localparam int WIDTH  = 2;
    localparam int CW     = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lut_mw_if #(.INPUTS(INPUTS), .WIDTH(WIDTH), .CONFIG_WIDTH(CW)) bus ();

    lut_mw #(.INPUTS(INPUTS), .WIDTH(WIDTH), .CONFIG_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chunk(input logic [CW-1:0] c);
        bus.cen       = 1'b1;
        bus.config_in = c;
        tick();
        bus.cen       = 1'b0;
    endtask

    task automatic read_at(input logic [INPUTS-1:0] a, input string tag, input logic [WIDTH-1:0] exp);
        bus.addr = a;
        #1;
        check_val(tag, 32'(bus.out), 32'(exp));
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.addr     = 4'd0;
        bus.cen      = 1'b0;
        bus.config_in= 8'h00;
        bus.waddr    = 4'd0;
        bus.data_in  = 2'b00;
        bus.write_en = 1'b0;
`ifdef LUT_MW_SRL_EN
        bus.mode     = 1'b0;
`endif
        #12;
        check_val("reset_out", 32'(bus.out), 32'h0);
        check_val("reset_done", 32'(bus.config_done), 32'h0);
        rst_n = 1'b1;
        tick();

        // Straight load: flat = {A5,3C,FF,01}, plane0 = FF01, plane1 = A53C
        chunk(8'hA5);
        chunk(8'h3C);
        chunk(8'hFF);
        check_val("load_done_3", 32'(bus.config_done), 32'h0);
        chunk(8'h01);
        check_val("load_done_4", 32'(bus.config_done), 32'h1);
        read_at(4'd0, "load_a0", 2'b01);
        read_at(4'd8, "load_a8", 2'b11);

        // RAM write with waddr == addr: old value until the edge
        bus.waddr    = 4'd3;
        bus.data_in  = 2'b01;
        bus.write_en = 1'b1;
        read_at(4'd3, "wr_before", 2'b10);
        tick();
        bus.write_en = 1'b0;
        check_val("wr_after", 32'(bus.out), 32'h1);

        // write_en with cen: ignored, flat {A5,34,FF,09} -> {34,FF,09,00}
        bus.waddr    = 4'd0;
        bus.data_in  = 2'b01;
        bus.write_en = 1'b1;
        bus.addr     = 4'd0;
        chunk(8'h00);
        bus.write_en = 1'b0;
        check_val("reconf_done_fall", 32'(bus.config_done), 32'h0);
        read_at(4'd0, "reconf_a0", 2'b10);

        // write_en during LOAD: ignored
        bus.write_en = 1'b1;
        tick();
        bus.write_en = 1'b0;
        read_at(4'd0, "load_wr_blocked", 2'b10);

        // Second chunk, then reset mid-load: flat {FF,09,00,11}
        chunk(8'h11);
        read_at(4'd0, "pre_reset_a0", 2'b11);
        rst_n = 1'b0;
        #1;
        check_val("midload_rst_out", 32'(bus.out), 32'h0);
        check_val("midload_rst_done", 32'(bus.config_done), 32'h0);
        #2;
        rst_n = 1'b1;

        // Paused load with blocked writes during the pause
        chunk(8'hA5);
        chunk(8'h3C);
        bus.addr     = 4'd2;
        bus.waddr    = 4'd2;
        bus.data_in  = 2'b00;
        bus.write_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.write_en = 1'b0;
        check_val("pause_hold", 32'(bus.out), 32'h1);
        check_val("pause_done", 32'(bus.config_done), 32'h0);
        chunk(8'hFF);
        check_val("pause_done_3", 32'(bus.config_done), 32'h0);
        chunk(8'h01);
        check_val("pause_done_4", 32'(bus.config_done), 32'h1);
        read_at(4'd0, "pause_a0", 2'b01);
        read_at(4'd8, "pause_a8", 2'b11);
        read_at(4'd3, "pause_a3", 2'b10);

        // Top-address write
        bus.waddr    = 4'd15;
        bus.data_in  = 2'b00;
        bus.write_en = 1'b1;
        read_at(4'd15, "top_before", 2'b11);
        tick();
        bus.write_en = 1'b0;
        check_val("top_after", 32'(bus.out), 32'h0);
        check_val("top_done_held", 32'(bus.config_done), 32'h1);

`ifdef LUT_MW_SRL_EN
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) chunk(8'h00);
        check_val("srl_loaded", 32'(bus.config_done), 32'h1);
        bus.mode     = 1'b1;
        bus.write_en = 1'b1;
        bus.data_in  = 2'b11;
        tick();
        bus.data_in  = 2'b00;
        for (int i = 0; i < 5; i++) tick();
        bus.write_en = 1'b0;
        read_at(4'd5, "srl_tap5", 2'b11);
        read_at(4'd4, "srl_tap4", 2'b00);
        bus.write_en = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check_val("srl_so_15", 32'(bus.shift_out), 32'h0);
        tick();
        check_val("srl_so_16", 32'(bus.shift_out), 32'h3);
        tick();
        check_val("srl_so_17", 32'(bus.shift_out), 32'h0);
        bus.write_en = 1'b0;
        bus.mode     = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
